// File: rtl/assoc_branch_target_buffer.sv
// Set-associative branch target buffer: one-cycle lookup of the first eligible branch in a
// fetch line, update/invalidate from branch resolution, and a post-reset clearing sweep.
module assoc_branch_target_buffer #(
  parameter int unsigned NUM_SETS  = 64,
  parameter int unsigned NUM_WAYS  = 4,
  parameter int unsigned TAG_BITS  = 10,
  parameter int unsigned FOFF_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IN_pcValid,
  input  logic [30:0]          IN_pc,
  output logic                 OUT_ready,
  output logic                 OUT_valid,
  output logic [30:0]          OUT_dst,
  output logic [1:0]           OUT_btype,
  output logic                 OUT_compr,
  output logic [FOFF_BITS-1:0] OUT_offs,
  output logic                 OUT_taken,
  output logic                 OUT_multiple,
  input  logic                 IN_upValid,
  input  logic                 IN_upClean,
  input  logic [31:0]          IN_upSrc,
  input  logic [31:0]          IN_upDst,
  input  logic [1:0]           IN_upBtype,
  input  logic                 IN_upCompr
);

  localparam int unsigned S = $clog2(NUM_SETS);
  localparam int unsigned W = $clog2(NUM_WAYS);

  typedef enum logic [1:0] {
    BT_BRANCH = 2'd0,
    BT_JUMP   = 2'd1,
    BT_CALL   = 2'd2,
    BT_RETURN = 2'd3
  } btype_e;

  typedef enum logic [1:0] {
    ST_SWEEP,
    ST_SETTLE,
    ST_READY
  } state_e;

  typedef struct packed {
    logic [TAG_BITS-1:0]  tag;
    logic [FOFF_BITS-1:0] offs;
    logic [30:0]          dst;
    logic [1:0]           btype;
    logic                 compr;
  } entry_t;

  // Valid bits live apart from the payload so sweep/clean touch a whole set in one write.
  logic [NUM_WAYS-1:0]              r_valid [NUM_SETS];
  entry_t [NUM_WAYS-1:0]            r_mem   [NUM_SETS];
  logic [W-1:0]                     r_ptr   [NUM_SETS];

  state_e                r_state;
  logic [S-1:0]          r_sweep;
  logic                  r_ready;
  logic                  r_fetchValid;
  logic [NUM_WAYS-1:0]   r_fetchVal;
  entry_t [NUM_WAYS-1:0] r_fetch;
  logic [TAG_BITS-1:0]   r_pcTag;
  logic [FOFF_BITS-1:0]  r_pcOffs;

  logic [S-1:0]          w_pcSet;
  logic [FOFF_BITS-1:0]  w_upOffs;
  logic [S-1:0]          w_upSet;
  logic [TAG_BITS-1:0]   w_upTag;
  logic [NUM_WAYS-1:0]   w_sameTag;
  logic                  w_hitFound;
  logic [W-1:0]          w_hitWay;
  logic                  w_invFound;
  logic [W-1:0]          w_invWay;
  logic [W-1:0]          w_wrWay;
  logic                  w_bump;
  entry_t                w_newEntry;
  logic                  w_sweeping;

  logic [NUM_WAYS-1:0]   w_match;
  logic                  w_any;
  logic [W-1:0]          w_sel;
  logic [FOFF_BITS-1:0]  w_selOffs;
  logic                  w_mult;
  logic                  w_unused;

  assign w_pcSet    = IN_pc[FOFF_BITS +: S];
  assign w_upOffs   = IN_upSrc[1 +: FOFF_BITS];
  assign w_upSet    = IN_upSrc[1+FOFF_BITS +: S];
  assign w_upTag    = IN_upSrc[1+FOFF_BITS+S +: TAG_BITS];
  assign w_sweeping = (r_state == ST_SWEEP);
  assign w_unused   = ^{IN_pc[30:FOFF_BITS+S+TAG_BITS], IN_upSrc[31:1+FOFF_BITS+S+TAG_BITS],
                        IN_upSrc[0], IN_upDst[0]};

  assign w_newEntry = '{tag: w_upTag, offs: w_upOffs, dst: IN_upDst[31:1],
                        btype: IN_upBtype, compr: IN_upCompr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_SWEEP;
      r_sweep      <= '0;
      r_ready      <= 1'b0;
      r_fetchValid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_SWEEP: begin
          r_sweep <= r_sweep + 1'b1;
          if (&r_sweep) r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          r_state <= ST_READY;
          r_ready <= 1'b1;
        end
        default: ;
      endcase
      if (IN_pcValid) r_fetchValid <= r_ready;
    end
  end

  // Update way choice: in-place overwrite, else lowest free way, else round-robin victim.
  always_comb begin
    w_sameTag  = '0;
    w_hitFound = 1'b0;
    w_hitWay   = '0;
    w_invFound = 1'b0;
    w_invWay   = '0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      w_sameTag[i] = r_valid[w_upSet][i] && (r_mem[w_upSet][i].tag == w_upTag) &&
                     (r_mem[w_upSet][i].offs == w_upOffs);
      if (w_sameTag[i] && !w_hitFound) begin
        w_hitFound = 1'b1;
        w_hitWay   = W'(i);
      end
      if (!r_valid[w_upSet][i] && !w_invFound) begin
        w_invFound = 1'b1;
        w_invWay   = W'(i);
      end
    end
    w_bump = !w_hitFound && !w_invFound;
    if (w_hitFound)      w_wrWay = w_hitWay;
    else if (w_invFound) w_wrWay = w_invWay;
    else                 w_wrWay = r_ptr[w_upSet];
  end

  always_ff @(posedge clk) begin
    if (IN_pcValid) begin
      r_fetchVal <= r_valid[w_pcSet];
      r_fetch    <= r_mem[w_pcSet];
      r_pcTag    <= IN_pc[FOFF_BITS+S +: TAG_BITS];
      r_pcOffs   <= IN_pc[FOFF_BITS-1:0];
    end
    if (w_sweeping) begin
      r_valid[r_sweep] <= '0;
      r_ptr[r_sweep]   <= '0;
    end else if (r_ready && IN_upValid) begin
      if (IN_upClean) begin
        r_valid[w_upSet] <= r_valid[w_upSet] & ~w_sameTag;
      end else begin
        r_valid[w_upSet][w_wrWay] <= 1'b1;
        r_mem[w_upSet][w_wrWay]   <= w_newEntry;
        if (w_bump) r_ptr[w_upSet] <= r_ptr[w_upSet] + 1'b1;
      end
    end
  end

  // Strict less-than while scanning upward keeps the lowest way on equal offsets.
  always_comb begin
    w_match   = '0;
    w_any     = 1'b0;
    w_sel     = '0;
    w_selOffs = '0;
    w_mult    = 1'b0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      w_match[i] = r_fetchVal[i] && (r_fetch[i].tag == r_pcTag) && (r_fetch[i].offs >= r_pcOffs);
    end
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (w_match[i] && (!w_any || (r_fetch[i].offs < w_selOffs))) begin
        w_any     = 1'b1;
        w_sel     = W'(i);
        w_selOffs = r_fetch[i].offs;
      end
    end
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (w_match[i] && (r_fetch[i].offs > w_selOffs)) w_mult = 1'b1;
    end
  end

  assign OUT_ready    = r_ready;
  assign OUT_valid    = r_fetchValid && w_any;
  assign OUT_dst      = r_fetch[w_sel].dst;
  assign OUT_btype    = r_fetch[w_sel].btype;
  assign OUT_compr    = r_fetch[w_sel].compr;
  assign OUT_offs     = w_selOffs;
  assign OUT_taken    = (r_fetch[w_sel].btype == BT_CALL) || (r_fetch[w_sel].btype == BT_JUMP);
  assign OUT_multiple = w_mult;

endmodule

// File: tb/tb_assoc_branch_target_buffer.sv
// Bench for assoc_branch_target_buffer: reset sweep timing, directed BTB scenarios and
// randomized traffic checked against an array-based reference model.
module tb_assoc_branch_target_buffer;

  localparam int SETS = 64;
  localparam int WAYS = 4;
  localparam logic [1:0] BT_BRANCH = 2'd0;
  localparam logic [1:0] BT_JUMP   = 2'd1;
  localparam logic [1:0] BT_CALL   = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IN_pcValid = 1'b0;
  logic [30:0] IN_pc = '0;
  logic        OUT_ready, OUT_valid, OUT_compr, OUT_taken, OUT_multiple;
  logic [30:0] OUT_dst;
  logic [1:0]  OUT_btype;
  logic [2:0]  OUT_offs;
  logic        IN_upValid = 1'b0;
  logic        IN_upClean = 1'b0;
  logic [31:0] IN_upSrc = '0;
  logic [31:0] IN_upDst = '0;
  logic [1:0]  IN_upBtype = '0;
  logic        IN_upCompr = 1'b0;

  assoc_branch_target_buffer #(.NUM_SETS(64), .NUM_WAYS(4), .TAG_BITS(10), .FOFF_BITS(3)) dut (
    .clk(clk), .rst(rst), .IN_pcValid(IN_pcValid), .IN_pc(IN_pc), .OUT_ready(OUT_ready),
    .OUT_valid(OUT_valid), .OUT_dst(OUT_dst), .OUT_btype(OUT_btype), .OUT_compr(OUT_compr),
    .OUT_offs(OUT_offs), .OUT_taken(OUT_taken), .OUT_multiple(OUT_multiple),
    .IN_upValid(IN_upValid), .IN_upClean(IN_upClean), .IN_upSrc(IN_upSrc), .IN_upDst(IN_upDst),
    .IN_upBtype(IN_upBtype), .IN_upCompr(IN_upCompr));

  always #5 clk = ~clk;

  // Reference model: plain per-set arrays of entries plus a victim counter.
  logic        m_valid [SETS][WAYS];
  logic [9:0]  m_tag   [SETS][WAYS];
  logic [2:0]  m_offs  [SETS][WAYS];
  logic [30:0] m_dst   [SETS][WAYS];
  logic [1:0]  m_bt    [SETS][WAYS];
  logic        m_compr [SETS][WAYS];
  int          m_ptr   [SETS];

  logic        e_valid, e_compr, e_taken, e_mult;
  logic [2:0]  e_offs;
  logic [30:0] e_dst;
  logic [1:0]  e_bt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
    e_valid = 1'b0;
  endtask

  task automatic model_lookup(input logic [30:0] pc);
    int set, tag, offs, minoffs, best;
    tag = int'(pc[18:9]); set = int'(pc[8:3]); offs = int'(pc[2:0]);
    minoffs = 8; best = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[set][w] && int'(m_tag[set][w]) == tag && int'(m_offs[set][w]) >= offs &&
          int'(m_offs[set][w]) < minoffs)
        minoffs = int'(m_offs[set][w]);
    e_valid = (minoffs < 8);
    e_mult  = 1'b0;
    if (e_valid) begin
      for (int w = WAYS - 1; w >= 0; w--)
        if (m_valid[set][w] && int'(m_tag[set][w]) == tag && int'(m_offs[set][w]) == minoffs)
          best = w;
      for (int w = 0; w < WAYS; w++)
        if (m_valid[set][w] && int'(m_tag[set][w]) == tag && int'(m_offs[set][w]) > minoffs)
          e_mult = 1'b1;
      e_offs  = m_offs[set][best];
      e_dst   = m_dst[set][best];
      e_bt    = m_bt[set][best];
      e_compr = m_compr[set][best];
      e_taken = (e_bt == BT_JUMP) || (e_bt == BT_CALL);
    end
  endtask

  task automatic model_update(input logic [31:0] src, input logic [31:0] dst,
                              input logic [1:0] bt, input logic compr, input logic clean);
    int set, tag, offs, way;
    offs = int'(src[3:1]); set = int'(src[9:4]); tag = int'(src[19:10]);
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (way < 0 && m_valid[set][w] && int'(m_tag[set][w]) == tag && int'(m_offs[set][w]) == offs)
        way = w;
    if (clean) begin
      for (int w = 0; w < WAYS; w++)
        if (m_valid[set][w] && int'(m_tag[set][w]) == tag && int'(m_offs[set][w]) == offs)
          m_valid[set][w] = 1'b0;
    end else begin
      for (int w = 0; w < WAYS; w++)
        if (way < 0 && !m_valid[set][w]) way = w;
      if (way < 0) begin
        way = m_ptr[set];
        m_ptr[set] = (m_ptr[set] + 1) % WAYS;
      end
      m_valid[set][way] = 1'b1;
      m_tag[set][way]   = src[19:10];
      m_offs[set][way]  = src[3:1];
      m_dst[set][way]   = dst[31:1];
      m_bt[set][way]    = bt;
      m_compr[set][way] = compr;
    end
  endtask

  // One clock of traffic; the lookup sees the model state before this cycle's update.
  task automatic cyc(input logic upv, input logic clean, input logic [31:0] src,
                     input logic [31:0] dst, input logic [1:0] bt, input logic compr,
                     input logic pcv, input logic [30:0] pc);
    IN_upValid = upv; IN_upClean = clean; IN_upSrc = src; IN_upDst = dst;
    IN_upBtype = bt; IN_upCompr = compr; IN_pcValid = pcv; IN_pc = pc;
    if (pcv) model_lookup(pc);
    if (upv) model_update(src, dst, bt, compr, clean);
    step();
    IN_upValid = 1'b0; IN_pcValid = 1'b0;
    chk("valid", 32'(OUT_valid), 32'(e_valid));
    if (e_valid) begin
      chk("offs", 32'(OUT_offs), 32'(e_offs));
      chk("dst", 32'(OUT_dst), 32'(e_dst));
      chk("btype", 32'(OUT_btype), 32'(e_bt));
      chk("compr", 32'(OUT_compr), 32'(e_compr));
      chk("taken", 32'(OUT_taken), 32'(e_taken));
      chk("multiple", 32'(OUT_multiple), 32'(e_mult));
    end
  endtask

  task automatic upd(input logic [31:0] src, input logic [31:0] dst, input logic [1:0] bt);
    cyc(1'b1, 1'b0, src, dst, bt, 1'b0, 1'b0, '0);
  endtask

  task automatic cln(input logic [31:0] src);
    cyc(1'b1, 1'b1, src, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic look(input logic [30:0] pc);
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, pc);
  endtask

  task automatic sweep_wait(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      chk("sweep_ready", 32'(OUT_ready), 32'd0);
      chk("sweep_valid", 32'(OUT_valid), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] src, dst;
    logic [30:0] pc;
    int set, tag;

    // Reset sweep, with a lookup held high throughout to confirm no prediction leaks out.
    IN_pcValid = 1'b1; IN_pc = 31'h800; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready", 32'(OUT_ready), 32'd0);
    sweep_wait(64);
    step();
    chk("ready_rise", 32'(OUT_ready), 32'd1);
    chk("ready_valid", 32'(OUT_valid), 32'd0);

    // Sweep restart: reset again at cycle 30 of a sweep.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    sweep_wait(30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sweep_wait(64);
    step();
    chk("restart_ready", 32'(OUT_ready), 32'd1);
    IN_pcValid = 1'b0;
    model_clear();

    // Basic hit.
    upd(32'h1004, 32'h2000, BT_JUMP);
    look(31'h800);
    chk("basic_valid", 32'(OUT_valid), 32'd1);
    chk("basic_offs", 32'(OUT_offs), 32'd2);
    chk("basic_dst", 32'(OUT_dst), 32'h1000);
    chk("basic_taken", 32'(OUT_taken), 32'd1);
    chk("basic_mult", 32'(OUT_multiple), 32'd0);
    look(31'h803);
    chk("basic_miss", 32'(OUT_valid), 32'd0);

    // Clean: wrong offset is a no-op, exact match invalidates.
    cln(32'h1006);
    look(31'h800);
    chk("clean_nomatch", 32'(OUT_valid), 32'd1);
    cln(32'h1004);
    look(31'h800);
    chk("clean_hit", 32'(OUT_valid), 32'd0);

    // Two branches in one line.
    upd(32'h1004, 32'h2000, BT_BRANCH);
    upd(32'h100A, 32'h3000, BT_JUMP);
    look(31'h800);
    chk("multi_offs", 32'(OUT_offs), 32'd2);
    chk("multi_taken", 32'(OUT_taken), 32'd0);
    chk("multi_mult", 32'(OUT_multiple), 32'd1);
    look(31'h803);
    chk("multi2_offs", 32'(OUT_offs), 32'd5);
    chk("multi2_dst", 32'(OUT_dst), 32'h1800);
    chk("multi2_mult", 32'(OUT_multiple), 32'd0);
    cln(32'h1004);
    cln(32'h100A);

    // Same-cycle update and lookup: lookup reads the old set.
    cyc(1'b1, 1'b0, 32'h1004, 32'h2000, BT_JUMP, 1'b0, 1'b1, 31'h800);
    chk("collide_old", 32'(OUT_valid), 32'd0);
    look(31'h800);
    chk("collide_next", 32'(OUT_valid), 32'd1);
    cln(32'h1004);

    // Replacement in set 0.
    upd(32'h1000, 32'h4000, BT_JUMP);
    upd(32'h1400, 32'h4400, BT_JUMP);
    upd(32'h1800, 32'h4800, BT_JUMP);
    upd(32'h1C00, 32'h4C00, BT_JUMP);
    upd(32'h2000, 32'h5000, BT_JUMP);
    look(31'h800);
    chk("evict_miss", 32'(OUT_valid), 32'd0);
    look(31'h1000);
    chk("evict_new", 32'(OUT_dst), 32'h2800);
    upd(32'h1400, 32'h5550, BT_CALL);
    look(31'hA00);
    chk("rewrite_dst", 32'(OUT_dst), 32'h2AA8);
    upd(32'h2400, 32'h6000, BT_JUMP);
    look(31'hA00);
    chk("ptr_victim", 32'(OUT_valid), 32'd0);
    look(31'hC00);
    chk("ptr_keep", 32'(OUT_valid), 32'd1);

    // Randomized traffic on two sets with more tags than ways.
    for (int n = 0; n < 600; n++) begin
      set = ($urandom_range(0, 1) == 0) ? 0 : 5;
      tag = $urandom_range(4, 9);
      src = ($urandom() & 32'hFFF0_0001) | (32'(tag) << 10) | (32'(set) << 4) |
            (32'($urandom_range(0, 7)) << 1);
      dst = $urandom();
      pc  = 31'($urandom() & 32'h7FF8_0000) | (31'($urandom_range(4, 9)) << 9) |
            (31'(set) << 3) | 31'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 4) == 0), src, dst,
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/assoc_branch_target_buffer.md
# assoc_branch_target_buffer

Set-associative, parametrised branch target buffer for the fetch stage. It predicts the first taken-candidate branch in a fetch line and flags whether further branches follow it in the same line. Each set holds NUM_WAYS entries, each tagged with its own fetch offset, so several branches per line can coexist without borrowing neighbouring slots. Lookup is one cycle through synchronous RAM; updates come from branch resolution, and a reset sweep clears the arrays after an asynchronous reset.

## Interface
- NUM_SETS, 64, number of sets; power of two; S = log2(NUM_SETS)
- NUM_WAYS, 4, entries per set; power of two, at least 2
- TAG_BITS, 10, stored tag width
- FOFF_BITS, 3, fetch-offset width in halfwords (line = 2^FOFF_BITS halfwords)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- IN_pcValid  in  1  lookup request
- IN_pc  in  31  halfword fetch PC: offs = [FOFF_BITS-1:0], set = [FOFF_BITS +: S], tag = [FOFF_BITS+S +: TAG_BITS]
- OUT_ready  out  1  high once the reset sweep is done
- OUT_valid  out  1  prediction valid
- OUT_dst  out  31  predicted target (halfword)
- OUT_btype  out  2  BranchType of the hit entry
- OUT_compr  out  1  compressed branch
- OUT_offs  out  FOFF_BITS  offset of the predicted branch in the line
- OUT_taken  out  1  btype is BT_CALL or BT_JUMP
- OUT_multiple  out  1  another matching entry exists at a larger offset
- IN_upValid  in  1  update strobe
- IN_upClean  in  1  invalidate instead of write
- IN_upSrc  in  32  byte address of the branch: offs = [1 +: FOFF_BITS], set = [1+FOFF_BITS +: S], tag = [1+FOFF_BITS+S +: TAG_BITS]
- IN_upDst  in  32  byte target; bits [31:1] are stored
- IN_upBtype  in  2  branch type
- IN_upCompr  in  1  compressed

## Operation
- **Entry contents:** valid, tag, offs, dst, btype, compr. Each set also has a log2(NUM_WAYS)-bit round-robin victim pointer.
- **Reset sweep:**
  - rst asserted: sweep counter = 0, OUT_ready = 0, fetched register invalid, OUT_valid = 0.
  - After rst deasserts, the block clears one set per cycle (all ways invalid, pointer 0) for NUM_SETS cycles. OUT_ready rises in the cycle after the last set is cleared.
  - rst asserted mid-sweep restarts the sweep from 0.
  - While OUT_ready = 0, updates are dropped and OUT_valid = 0.
- **Lookup:** with IN_pcValid, register the whole set and IN_pc. Without IN_pcValid, hold the registered values. Combinational hit logic runs after the register:
  - Match = valid and tag equal and entry offs >= pc offs.
  - Chosen = matching way with the smallest offs. If offs ties, the lowest way index wins.
  - OUT_valid = any match. OUT_multiple = some other match has offs > chosen offs.
  - When OUT_valid = 0, the other outputs are don't-care.
- **Update, write:** target set and tag come from IN_upSrc. Way selection, first rule that applies:
  1. the way with valid and the same tag and offs (overwrite in place);
  2. else the lowest invalid way;
  3. else the way at the victim pointer, then pointer increments modulo NUM_WAYS.
  - Only rule 3 moves the pointer.
- **Update, clean:** clear valid in every way of the set whose tag and offs match. The pointer is unchanged. No match means no effect.
- **Lookup/update collision:** an update and a lookup to the same set in the same cycle give read-first behaviour. The lookup sees the pre-update contents.

## Timing
- Lookup latency is 1 cycle: IN_pc sampled at edge N, prediction valid after edge N until the next IN_pcValid.
- An update written at edge N is visible to a lookup issued at edge N+1 or later.
- At most one update per cycle. Updates have no backpressure other than OUT_ready.
- Reset to ready: NUM_SETS + 1 cycles after rst deasserts.

## Test plan
Defaults apply.
- **Reset sweep:** assert rst for 3 cycles, deassert -> OUT_ready = 0 for 64 cycles, 1 on cycle 65. OUT_valid = 0 throughout. Assert rst at cycle 30 -> sweep restarts and takes the full 65 cycles again.
- **Basic hit:**
  - Update src = 0x00001004, dst = 0x00002000, btype = BT_JUMP.
  - Lookup IN_pc = 0x800 -> OUT_valid = 1, OUT_offs = 2, OUT_dst = 0x1000, OUT_taken = 1, OUT_multiple = 0.
  - Lookup IN_pc = 0x803 -> OUT_valid = 0.
- **Multiple branches in a line:** updates at 0x1004 (BT_BRANCH) and 0x100A (BT_JUMP).
  - Lookup 0x800 -> offs 2, OUT_taken = 0, OUT_multiple = 1.
  - Lookup 0x803 -> offs 5, OUT_multiple = 0.
- **Replacement:** write 5 distinct tags into set 0 (src = 0x1000, 0x1400, 0x1800, 0x1C00, 0x2000) -> the fifth evicts way 0 (tag 4), so lookup 0x800 misses. Rewriting 0x1400 with a new dst changes only its dst; the victim pointer stays at 1.
- **Clean:** entry at 0x1004, issue a clean for 0x1004 -> lookup 0x800 misses. Clean for 0x1006 when no entry has that offset -> no change.
- **Collision:** update 0x1004 and lookup 0x800 in the same cycle -> OUT_valid = 0. Lookup at the next edge -> OUT_valid = 1.
